// File: rtl/s2p_pkg.sv
// Shared sizing defaults and helpers for the ping-pong serial-to-parallel packer.
package s2p_pkg;

  localparam int unsigned DWI_DEF   = 128;
  localparam int unsigned NBEAT_DEF = 14;
  localparam int unsigned DWO       = DWI_DEF * NBEAT_DEF;
  localparam int unsigned CW        = $clog2(NBEAT_DEF + 1);

  // Zero or an over-range request means a full-length line.
  function automatic int unsigned nbeat_eff(input int unsigned cfg, input int unsigned nbeat);
    return (cfg == 0 || cfg > nbeat) ? nbeat : cfg;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned i, input bit msb_first,
                                           input int unsigned nbeat, input int unsigned dwi);
    return msb_first ? (nbeat - 1 - i) * dwi : i * dwi;
  endfunction

endpackage

// File: rtl/s2p_bank.sv
// One line buffer: per-slice writes, zeroed on release, full flag and recorded beat count.
module s2p_bank
  import s2p_pkg::*;
#(
  parameter int unsigned DWI       = 128,
  parameter int unsigned NBEAT     = 14,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned DWO      = DWI * NBEAT,
  localparam int unsigned CW       = $clog2(NBEAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           pop,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_idx,
  input  logic [DWI-1:0] wr_data,
  input  logic           close,
  input  logic [CW-1:0]  close_nbeat,
  output logic [DWO-1:0] data,
  output logic           full,
  output logic [CW-1:0]  nbeat
);

  logic          full_q;
  logic [CW-1:0] nbeat_q;

  for (genvar s = 0; s < NBEAT; s++) begin : g_slice
    logic [DWI-1:0] slice_q;
    logic           we;

    assign we = wr_en &&
                (slice_lo(32'(wr_idx), MSB_FIRST, NBEAT, DWI) == 32'(s) * DWI);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slice_q <= '0;
      end else if (clr || pop) begin
        slice_q <= '0;
      end else if (we) begin
        slice_q <= wr_data;
      end
    end

    assign data[s*DWI +: DWI] = slice_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      nbeat_q <= '0;
    end else if (clr || pop) begin
      full_q  <= 1'b0;
      nbeat_q <= '0;
    end else if (close) begin
      full_q  <= 1'b1;
      nbeat_q <= close_nbeat;
    end
  end

  assign full  = full_q;
  assign nbeat = nbeat_q;

endmodule

// File: rtl/ser2par_pp.sv
// Ping-pong serial-to-parallel packer: fills one bank while the other waits for its consumer.
module ser2par_pp
  import s2p_pkg::*;
#(
  parameter int unsigned DWI       = 128,
  parameter int unsigned NBEAT     = 14,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned DWO      = DWI * NBEAT,
  localparam int unsigned CW       = $clog2(NBEAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [CW-1:0]  cfg_nbeat,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DWI-1:0] s_data,
  input  logic           s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DWO-1:0] m_data,
  output logic [CW-1:0]  m_nbeat
);

  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] len_cur;
  logic          accept, close, pop;

  logic [1:0]     full;
  logic [DWO-1:0] bank_data  [2];
  logic [CW-1:0]  bank_nbeat [2];

  assign s_ready = !clr && !full[wr_sel_q];
  assign accept  = s_valid && s_ready;
  assign m_valid = full[rd_sel_q];
  assign pop     = m_valid && m_ready && !clr;

  // Frame length is only taken from cfg_nbeat on the first beat of a frame.
  always_comb begin
    len_cur = len_q;
    if (count_q == '0) begin
      len_cur = CW'(nbeat_eff(32'(cfg_nbeat), NBEAT));
    end
  end

  assign close = accept && (s_last || (count_q == len_cur - CW'(1)));

  always_comb begin
    count_d  = count_q;
    len_d    = len_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (clr) begin
      count_d  = '0;
      len_d    = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (accept) begin
        len_d   = len_cur;
        count_d = close ? '0 : count_q + CW'(1);
      end
      if (close) begin
        wr_sel_d = !wr_sel_q;
      end
      if (pop) begin
        rd_sel_d = !rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= '0;
      len_q    <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      count_q  <= count_d;
      len_q    <= len_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic wr_hit, rd_hit;

    assign wr_hit = (wr_sel_q == 1'(b));
    assign rd_hit = (rd_sel_q == 1'(b));

    s2p_bank #(
      .DWI       (DWI),
      .NBEAT     (NBEAT),
      .MSB_FIRST (MSB_FIRST)
    ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .pop         (pop && rd_hit),
      .wr_en       (accept && wr_hit),
      .wr_idx      (count_q),
      .wr_data     (s_data),
      .close       (close && wr_hit),
      .close_nbeat (count_q + CW'(1)),
      .data        (bank_data[b]),
      .full        (full[b]),
      .nbeat       (bank_nbeat[b])
    );
  end

  // The read bank may be the one being filled, so mask it until it is full.
  always_comb begin
    m_data  = '0;
    m_nbeat = '0;
    if (m_valid) begin
      m_data  = bank_data[rd_sel_q];
      m_nbeat = bank_nbeat[rd_sel_q];
    end
  end

endmodule
